arc4_ctrl: RTL and testbench
============================

ARC4_CTRL -- requirements
Module: arc4_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all logic on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: en  in  1  start request; rdy  out  1  ready for request; done  out  1  one-cycle completion pulse.
REQ-004 SHALL have ports: key  in  24  cipher key, captured on accepted request; ksa_key  out  24  captured key.
REQ-005 SHALL have ports: init_en, ksa_en, prga_en  out  1 each  sub-unit start; init_rdy, ksa_rdy, prga_rdy  in  1 each  sub-unit ready.
REQ-006 SHALL have ports: {init,ksa,prga}_addr  in  8; {init,ksa,prga}_wrdata  in  8; {init,ksa,prga}_wren  in  1  sub-unit S-memory requests.
REQ-007 SHALL have ports: s_addr  out  8; s_wrdata  out  8; s_wren  out  1  muxed S-memory port.

Function
REQ-008 SHALL accept a request on a clock edge where en=1 and rdy=1; en while rdy=0 SHALL be ignored.
REQ-009 SHALL capture key into ksa_key on the accepting edge and hold it until the next accepted request.
REQ-010 SHALL implement states IDLE, INIT_REQ, INIT_WAIT, KSA_REQ, KSA_WAIT, PRGA_REQ, PRGA_WAIT.
REQ-011 SHALL drive rdy=1 only in IDLE; IDLE -> INIT_REQ on accepted request.
REQ-012 In an X_REQ state SHALL assert X_en=1 combinationally only while X_rdy=1, and move to X_WAIT on that edge; while X_rdy=0, remain in X_REQ with X_en=0.
REQ-013 Each X_en SHALL be high for exactly one cycle per phase; never two enables high simultaneously.
REQ-014 X_WAIT SHALL set a seen_busy flag when X_rdy=0 is sampled and advance only on an edge with X_rdy=1 and seen_busy=1; seen_busy clears on entering any X_REQ.
REQ-015 Transitions: INIT_WAIT -> KSA_REQ, KSA_WAIT -> PRGA_REQ, PRGA_WAIT -> IDLE.
REQ-016 On PRGA_WAIT -> IDLE SHALL pulse done=1 for exactly one cycle, coincident with rdy returning to 1.
REQ-017 Latency: request accepted at edge N with all sub-units ready -> init_en=1 during cycle N+1.
REQ-018 S-memory owner: INIT_* -> init port, KSA_* -> ksa port, PRGA_* -> prga port; s_addr/s_wrdata/s_wren SHALL equal the owner's inputs combinationally.
REQ-019 In IDLE SHALL drive s_addr=0, s_wrdata=0, s_wren=0; non-owner wren SHALL never reach s_wren.
REQ-020 Sub-unit rdy staying high (never dropping) SHALL hold the controller in X_WAIT indefinitely; no timeout.
REQ-021 en held high continuously SHALL start a new run on the edge rdy=1 is sampled, i.e. back-to-back runs.

Reset
REQ-022 rst=1 SHALL immediately force IDLE, rdy=1, done=0, all X_en=0, s_wren=0, s_addr=0, s_wrdata=0, ksa_key=0, seen_busy=0, independent of clk.
REQ-023 Reset mid-operation SHALL abandon the run; after release, no sub-unit enable asserts until a new accepted request.

Structure
REQ-024 Shared package arc4_pkg SHALL hold the state enum, KEY_W=24, ADDR_W=8, DATA_W=8.
REQ-025 The S-memory port multiplexer SHALL be a separate sub-module s_port_mux selected by a 2-bit owner code from arc4_pkg.

Verification
REQ-026 Normal run: key=24'h00033C, en pulse, each sub-unit drops rdy 1 cycle after its en and raises it 10 cycles later -> init_en, ksa_en, prga_en each pulse once in order, ksa_key=24'h00033C, done pulses once, rdy=1 after.
REQ-027 Busy sub-unit: ksa_rdy held 0 for 5 cycles at KSA_REQ -> ksa_en stays 0 until ksa_rdy=1, then pulses exactly one cycle.
REQ-028 Mux check: ksa_addr=8'h2A, ksa_wrdata=8'h55, ksa_wren=1, init_wren=1 during KSA_WAIT -> s_addr=8'h2A, s_wrdata=8'h55, s_wren=1; in IDLE with all wren=1 -> s_wren=0.
REQ-029 Ignored request: en=1 with key=24'hFFFFFF during INIT_WAIT -> ksa_key unchanged, no extra init_en.
REQ-030 Reset mid-run: rst=1 during KSA_WAIT, released, sub-units idle -> rdy=1, s_wren=0, ksa_key=0, no enable until next en.
REQ-031 Back-to-back: en held high across completion -> done pulse and new init_en one cycle apart.

Source files
------------

// File: rtl/arc4_pkg.sv
// ============================================================================
// Module      : arc4_pkg
// Description : Shared types and constants for the ARC4 control path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arc4_pkg;

   localparam int KEY_W  = 24;
   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_INIT_REQ  = 3'd1,
      ST_INIT_WAIT = 3'd2,
      ST_KSA_REQ   = 3'd3,
      ST_KSA_WAIT  = 3'd4,
      ST_PRGA_REQ  = 3'd5,
      ST_PRGA_WAIT = 3'd6
   } state_t;

   // Which sub-unit currently drives the shared S-memory port.
   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_INIT = 2'd1;
   localparam logic [1:0] OWN_KSA  = 2'd2;
   localparam logic [1:0] OWN_PRGA = 2'd3;

   function automatic logic [1:0] state_owner(input state_t s);
      logic [1:0] own;
      own = OWN_NONE;
      case (s)
         ST_INIT_REQ, ST_INIT_WAIT: own = OWN_INIT;
         ST_KSA_REQ,  ST_KSA_WAIT:  own = OWN_KSA;
         ST_PRGA_REQ, ST_PRGA_WAIT: own = OWN_PRGA;
         default:                   own = OWN_NONE;
      endcase
      return own;
   endfunction

endpackage

`default_nettype wire

// File: rtl/s_port_mux.sv
// ============================================================================
// Module      : s_port_mux
// Description : Routes the owning sub-unit's request onto the S-memory port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module s_port_mux
   import arc4_pkg::*;
(
   input  logic [1:0]        owner_i,
   input  logic [ADDR_W-1:0] init_addr_i,
   input  logic [DATA_W-1:0] init_wrdata_i,
   input  logic              init_wren_i,
   input  logic [ADDR_W-1:0] ksa_addr_i,
   input  logic [DATA_W-1:0] ksa_wrdata_i,
   input  logic              ksa_wren_i,
   input  logic [ADDR_W-1:0] prga_addr_i,
   input  logic [DATA_W-1:0] prga_wrdata_i,
   input  logic              prga_wren_i,
   output logic [ADDR_W-1:0] s_addr_o,
   output logic [DATA_W-1:0] s_wrdata_o,
   output logic              s_wren_o
);

   always_comb begin
      s_addr_o   = '0;
      s_wrdata_o = '0;
      s_wren_o   = 1'b0;
      case (owner_i)
         OWN_INIT: begin
            s_addr_o   = init_addr_i;
            s_wrdata_o = init_wrdata_i;
            s_wren_o   = init_wren_i;
         end
         OWN_KSA: begin
            s_addr_o   = ksa_addr_i;
            s_wrdata_o = ksa_wrdata_i;
            s_wren_o   = ksa_wren_i;
         end
         OWN_PRGA: begin
            s_addr_o   = prga_addr_i;
            s_wrdata_o = prga_wrdata_i;
            s_wren_o   = prga_wren_i;
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/arc4_ctrl.sv
// ============================================================================
// Module      : arc4_ctrl
// Description : Sequences init, KSA and PRGA sub-units and arbitrates S-memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arc4_ctrl
   import arc4_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   output logic              rdy,
   output logic              done,
   input  logic [KEY_W-1:0]  key,
   output logic [KEY_W-1:0]  ksa_key,
   output logic              init_en,
   output logic              ksa_en,
   output logic              prga_en,
   input  logic              init_rdy,
   input  logic              ksa_rdy,
   input  logic              prga_rdy,
   input  logic [ADDR_W-1:0] init_addr,
   input  logic [DATA_W-1:0] init_wrdata,
   input  logic              init_wren,
   input  logic [ADDR_W-1:0] ksa_addr,
   input  logic [DATA_W-1:0] ksa_wrdata,
   input  logic              ksa_wren,
   input  logic [ADDR_W-1:0] prga_addr,
   input  logic [DATA_W-1:0] prga_wrdata,
   input  logic              prga_wren,
   output logic [ADDR_W-1:0] s_addr,
   output logic [DATA_W-1:0] s_wrdata,
   output logic              s_wren
);

   state_t           state_q, state_d;
   logic             seen_busy_q, seen_busy_d;
   logic             done_q, done_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic [1:0]       owner;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         seen_busy_q <= 1'b0;
         done_q      <= 1'b0;
         key_q       <= '0;
      end else begin
         state_q     <= state_d;
         seen_busy_q <= seen_busy_d;
         done_q      <= done_d;
         key_q       <= key_d;
      end
   end

   // A WAIT state only advances after the sub-unit has been seen busy, so a
   // sub-unit that has not yet reacted to its enable is not mistaken for done.
   always_comb begin
      state_d     = state_q;
      seen_busy_d = seen_busy_q;
      done_d      = 1'b0;
      key_d       = key_q;
      rdy         = 1'b0;
      init_en     = 1'b0;
      ksa_en      = 1'b0;
      prga_en     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            rdy = 1'b1;
            if (en) begin
               state_d = ST_INIT_REQ;
               key_d   = key;
            end
         end
         ST_INIT_REQ: begin
            seen_busy_d = 1'b0;
            if (init_rdy) begin
               init_en = 1'b1;
               state_d = ST_INIT_WAIT;
            end
         end
         ST_INIT_WAIT: begin
            if (!init_rdy)        seen_busy_d = 1'b1;
            else if (seen_busy_q) state_d     = ST_KSA_REQ;
         end
         ST_KSA_REQ: begin
            seen_busy_d = 1'b0;
            if (ksa_rdy) begin
               ksa_en  = 1'b1;
               state_d = ST_KSA_WAIT;
            end
         end
         ST_KSA_WAIT: begin
            if (!ksa_rdy)         seen_busy_d = 1'b1;
            else if (seen_busy_q) state_d     = ST_PRGA_REQ;
         end
         ST_PRGA_REQ: begin
            seen_busy_d = 1'b0;
            if (prga_rdy) begin
               prga_en = 1'b1;
               state_d = ST_PRGA_WAIT;
            end
         end
         ST_PRGA_WAIT: begin
            if (!prga_rdy) begin
               seen_busy_d = 1'b1;
            end else if (seen_busy_q) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign done    = done_q;
   assign ksa_key = key_q;
   assign owner   = state_owner(state_q);

   s_port_mux u_s_port_mux (
      .owner_i       (owner),
      .init_addr_i   (init_addr),
      .init_wrdata_i (init_wrdata),
      .init_wren_i   (init_wren),
      .ksa_addr_i    (ksa_addr),
      .ksa_wrdata_i  (ksa_wrdata),
      .ksa_wren_i    (ksa_wren),
      .prga_addr_i   (prga_addr),
      .prga_wrdata_i (prga_wrdata),
      .prga_wren_i   (prga_wren),
      .s_addr_o      (s_addr),
      .s_wrdata_o    (s_wrdata),
      .s_wren_o      (s_wren)
   );

endmodule

`default_nettype wire

// File: tb/tb_arc4_ctrl.sv
// ============================================================================
// Module      : tb_arc4_ctrl
// Description : Directed self-checking bench for arc4_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arc4_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en  = 1'b0;
   logic        rdy, done;
   logic [23:0] key = '0;
   logic [23:0] ksa_key;
   logic        init_en, ksa_en, prga_en;
   logic        init_rdy = 1'b1, ksa_rdy = 1'b1, prga_rdy = 1'b1;
   logic [7:0]  init_addr = '0, ksa_addr = '0, prga_addr = '0;
   logic [7:0]  init_wrdata = '0, ksa_wrdata = '0, prga_wrdata = '0;
   logic        init_wren = 1'b0, ksa_wren = 1'b0, prga_wren = 1'b0;
   logic [7:0]  s_addr, s_wrdata;
   logic        s_wren;

   int checks = 0;
   int errors = 0;

   // Sub-unit ready either follows a busy model or a manual value.
   logic auto_init = 1'b0, auto_ksa = 1'b0, auto_prga = 1'b0;
   logic man_init_rdy = 1'b1, man_ksa_rdy = 1'b1, man_prga_rdy = 1'b1;

   int   cyc = 0, n_init = 0, n_ksa = 0, n_prga = 0, n_done = 0;
   int   t_init = 0, t_ksa = 0, t_prga = 0;
   logic overlap = 1'b0;

   arc4_ctrl dut (
      .clk(clk), .rst(rst), .en(en), .rdy(rdy), .done(done),
      .key(key), .ksa_key(ksa_key),
      .init_en(init_en), .ksa_en(ksa_en), .prga_en(prga_en),
      .init_rdy(init_rdy), .ksa_rdy(ksa_rdy), .prga_rdy(prga_rdy),
      .init_addr(init_addr), .init_wrdata(init_wrdata), .init_wren(init_wren),
      .ksa_addr(ksa_addr), .ksa_wrdata(ksa_wrdata), .ksa_wren(ksa_wren),
      .prga_addr(prga_addr), .prga_wrdata(prga_wrdata), .prga_wren(prga_wren),
      .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren)
   );

   initial forever #5 clk = ~clk;

   // Sub-unit model: rdy drops the cycle after en, rises again 10 cycles later.
   initial begin
      logic p_i, p_k, p_p, m_i, m_k, m_p;
      int   c_i, c_k, c_p;
      m_i = 1'b1; m_k = 1'b1; m_p = 1'b1;
      c_i = 0;    c_k = 0;    c_p = 0;
      forever begin
         @(negedge clk);
         p_i = init_en; p_k = ksa_en; p_p = prga_en;
         @(posedge clk);
         #2;
         if (p_i) begin m_i = 1'b0; c_i = 10; end
         else if (c_i > 0) begin c_i--; if (c_i == 0) m_i = 1'b1; end
         if (p_k) begin m_k = 1'b0; c_k = 10; end
         else if (c_k > 0) begin c_k--; if (c_k == 0) m_k = 1'b1; end
         if (p_p) begin m_p = 1'b0; c_p = 10; end
         else if (c_p > 0) begin c_p--; if (c_p == 0) m_p = 1'b1; end
         init_rdy = auto_init ? m_i : man_init_rdy;
         ksa_rdy  = auto_ksa  ? m_k : man_ksa_rdy;
         prga_rdy = auto_prga ? m_p : man_prga_rdy;
      end
   end

   initial forever begin
      @(negedge clk);
      cyc++;
      if (init_en === 1'b1) begin n_init++; t_init = cyc; end
      if (ksa_en  === 1'b1) begin n_ksa++;  t_ksa  = cyc; end
      if (prga_en === 1'b1) begin n_prga++; t_prga = cyc; end
      if (done    === 1'b1) n_done++;
      if ((32'(init_en) + 32'(ksa_en) + 32'(prga_en)) > 1) overlap = 1'b1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_counts();
      n_init = 0; n_ksa = 0; n_prga = 0; n_done = 0; overlap = 1'b0;
   endtask

   task automatic start_run(input logic [23:0] k);
      tick();
      en  = 1'b1;
      key = k;
      tick();
      en  = 1'b0;
   endtask

   task automatic wait_done(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max && !ok; i++) begin
         @(negedge clk);
         if (done === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic wait_addr(input logic [7:0] a, input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max && !ok; i++) begin
         @(negedge clk);
         if (s_addr === a) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      init_addr = 8'h11; ksa_addr = 8'h22; prga_addr = 8'h33;
      init_wrdata = 8'hA1; ksa_wrdata = 8'hA2; prga_wrdata = 8'hA3;
      init_wren = 1'b1; ksa_wren = 1'b1; prga_wren = 1'b1;
      #1 rst = 1'b1;
      #2;
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b want 1", rdy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if ({init_en, ksa_en, prga_en} !== 3'b000) begin errors++; $display("FAIL reset_en: got %b want 000", {init_en, ksa_en, prga_en}); end
      checks++; if (s_wren !== 1'b0) begin errors++; $display("FAIL reset_s_wren: got %b want 0", s_wren); end
      checks++; if (s_addr !== 8'h00 || s_wrdata !== 8'h00) begin errors++; $display("FAIL reset_s_port: got %h/%h want 00/00", s_addr, s_wrdata); end
      checks++; if (ksa_key !== 24'h0) begin errors++; $display("FAIL reset_ksa_key: got %h want 000000", ksa_key); end
      repeat (2) tick();
      rst = 1'b0;
      init_wren = 1'b0; ksa_wren = 1'b0; prga_wren = 1'b0;
      tick();
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL post_reset_rdy: got %b want 1", rdy); end
   endtask

   task automatic test_normal();
      bit ok;
      auto_init = 1'b1; auto_ksa = 1'b1; auto_prga = 1'b1;
      clear_counts();
      start_run(24'h00033C);
      checks++; if (init_en !== 1'b1) begin errors++; $display("FAIL normal_init_latency: got %b want 1", init_en); end
      checks++; if (ksa_key !== 24'h00033C) begin errors++; $display("FAIL normal_key: got %h want 00033C", ksa_key); end
      wait_done(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL normal_done_timeout: got none want pulse"); end
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL normal_rdy_with_done: got %b want 1", rdy); end
      tick();
      checks++; if (done !== 1'b0 || rdy !== 1'b1) begin errors++; $display("FAIL normal_after: got done=%b rdy=%b want 0/1", done, rdy); end
      checks++; if (n_init != 1 || n_ksa != 1 || n_prga != 1) begin errors++; $display("FAIL normal_en_counts: got %0d/%0d/%0d want 1/1/1", n_init, n_ksa, n_prga); end
      checks++; if (!(t_init < t_ksa && t_ksa < t_prga)) begin errors++; $display("FAIL normal_order: got %0d/%0d/%0d want increasing", t_init, t_ksa, t_prga); end
      checks++; if (n_done != 1) begin errors++; $display("FAIL normal_done_count: got %0d want 1", n_done); end
      checks++; if (overlap !== 1'b0) begin errors++; $display("FAIL normal_overlap: got %b want 0", overlap); end
      checks++; if (ksa_key !== 24'h00033C) begin errors++; $display("FAIL normal_key_hold: got %h want 00033C", ksa_key); end
   endtask

   task automatic test_busy_ksa();
      bit ok;
      auto_init = 1'b1; auto_ksa = 1'b0; auto_prga = 1'b1;
      man_ksa_rdy = 1'b0;
      init_addr = 8'h11; ksa_addr = 8'h22; prga_addr = 8'h33;
      tick(); tick();
      clear_counts();
      start_run(24'h0A0B0C);
      wait_addr(8'h22, 100, ok);
      checks++; if (!ok) begin errors++; $display("FAIL busy_reach_ksa: got s_addr=%h want 22", s_addr); end
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         checks++; if (ksa_en !== 1'b0) begin errors++; $display("FAIL busy_ksa_en_low[%0d]: got %b want 0", i, ksa_en); end
      end
      @(posedge clk);
      #1 man_ksa_rdy = 1'b1;
      @(negedge clk);
      checks++; if (ksa_en !== 1'b1) begin errors++; $display("FAIL busy_ksa_en_pulse: got %b want 1", ksa_en); end
      @(negedge clk);
      checks++; if (ksa_en !== 1'b0) begin errors++; $display("FAIL busy_ksa_en_width: got %b want 0", ksa_en); end
      tick();
      man_ksa_rdy = 1'b0;
      tick(); tick();
      man_ksa_rdy = 1'b1;
      wait_done(100, ok);
      checks++; if (!ok) begin errors++; $display("FAIL busy_done_timeout: got none want pulse"); end
      tick();
      checks++; if (n_ksa != 1 || overlap !== 1'b0) begin errors++; $display("FAIL busy_ksa_count: got %0d overlap=%b want 1/0", n_ksa, overlap); end
   endtask

   task automatic test_mux();
      bit ok;
      auto_init = 1'b1; auto_ksa = 1'b0; auto_prga = 1'b1;
      man_ksa_rdy = 1'b1;
      ksa_addr = 8'h2A; ksa_wrdata = 8'h55;
      start_run(24'h00C0DE);
      wait_addr(8'h2A, 100, ok);
      checks++; if (!ok) begin errors++; $display("FAIL mux_reach_ksa: got s_addr=%h want 2A", s_addr); end
      tick();
      // ksa_rdy stays high without a busy phase, so KSA_WAIT is held
      ksa_wren = 1'b1; init_wren = 1'b1; prga_wren = 1'b1;
      repeat (3) tick();
      checks++; if (s_addr !== 8'h2A || s_wrdata !== 8'h55 || s_wren !== 1'b1) begin errors++; $display("FAIL mux_ksa_owner: got %h/%h/%b want 2A/55/1", s_addr, s_wrdata, s_wren); end
      ksa_wren = 1'b0;
      #1;
      checks++; if (s_wren !== 1'b0) begin errors++; $display("FAIL mux_nonowner_wren: got %b want 0", s_wren); end
      ksa_wren = 1'b1;
      man_ksa_rdy = 1'b0;
      tick(); tick();
      man_ksa_rdy = 1'b1;
      wait_done(100, ok);
      checks++; if (!ok) begin errors++; $display("FAIL mux_done_timeout: got none want pulse"); end
      tick();
      checks++; if (s_wren !== 1'b0 || s_addr !== 8'h00 || s_wrdata !== 8'h00) begin errors++; $display("FAIL mux_idle: got %h/%h/%b want 00/00/0", s_addr, s_wrdata, s_wren); end
      init_wren = 1'b0; ksa_wren = 1'b0; prga_wren = 1'b0;
   endtask

   task automatic test_ignored_req();
      bit ok;
      auto_init = 1'b1; auto_ksa = 1'b1; auto_prga = 1'b1;
      tick();
      clear_counts();
      start_run(24'h123456);
      tick(); tick();
      en = 1'b1; key = 24'hFFFFFF;
      tick(); tick(); tick();
      en = 1'b0;
      checks++; if (ksa_key !== 24'h123456) begin errors++; $display("FAIL ignored_key_mid: got %h want 123456", ksa_key); end
      wait_done(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL ignored_done_timeout: got none want pulse"); end
      tick();
      checks++; if (n_init != 1) begin errors++; $display("FAIL ignored_init_count: got %0d want 1", n_init); end
      checks++; if (ksa_key !== 24'h123456) begin errors++; $display("FAIL ignored_key_end: got %h want 123456", ksa_key); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      auto_init = 1'b1; auto_ksa = 1'b0; auto_prga = 1'b1;
      man_ksa_rdy = 1'b1;
      ksa_addr = 8'h2A; ksa_wren = 1'b1;
      start_run(24'hABCDEF);
      wait_addr(8'h2A, 100, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rstmid_reach_ksa: got s_addr=%h want 2A", s_addr); end
      tick();
      man_ksa_rdy = 1'b0;
      checks++; if (s_wren !== 1'b1 || ksa_key !== 24'hABCDEF) begin errors++; $display("FAIL rstmid_pre: got wren=%b key=%h want 1/ABCDEF", s_wren, ksa_key); end
      tick();
      #2 rst = 1'b1;
      #1;
      checks++; if (rdy !== 1'b1 || s_wren !== 1'b0 || s_addr !== 8'h00) begin errors++; $display("FAIL rstmid_async: got rdy=%b wren=%b addr=%h want 1/0/00", rdy, s_wren, s_addr); end
      checks++; if (ksa_key !== 24'h0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_key: got key=%h done=%b want 000000/0", ksa_key, done); end
      @(negedge clk);
      auto_init = 1'b0; auto_prga = 1'b0;
      man_init_rdy = 1'b1; man_ksa_rdy = 1'b1; man_prga_rdy = 1'b1;
      rst = 1'b0;
      tick();
      clear_counts();
      repeat (6) tick();
      checks++; if ((n_init + n_ksa + n_prga) != 0) begin errors++; $display("FAIL rstmid_no_enable: got %0d want 0", n_init + n_ksa + n_prga); end
      checks++; if (rdy !== 1'b1 || s_wren !== 1'b0 || ksa_key !== 24'h0) begin errors++; $display("FAIL rstmid_idle: got rdy=%b wren=%b key=%h want 1/0/000000", rdy, s_wren, ksa_key); end
      ksa_wren = 1'b0;
   endtask

   task automatic test_back_to_back();
      bit ok;
      auto_init = 1'b1; auto_ksa = 1'b1; auto_prga = 1'b1;
      tick();
      clear_counts();
      en = 1'b1; key = 24'h0F0F0F;
      tick();
      wait_done(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_first_done_timeout: got none want pulse"); end
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy_with_done: got %b want 1", rdy); end
      @(negedge clk);
      checks++; if (init_en !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_restart: got init_en=%b done=%b want 1/0", init_en, done); end
      tick();
      en = 1'b0;
      wait_done(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_second_done_timeout: got none want pulse"); end
      tick();
      checks++; if (n_done != 2 || n_init != 2) begin errors++; $display("FAIL b2b_counts: got done=%0d init=%0d want 2/2", n_done, n_init); end
      checks++; if (ksa_key !== 24'h0F0F0F) begin errors++; $display("FAIL b2b_key: got %h want 0F0F0F", ksa_key); end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_busy_ksa();
      test_mux();
      test_ignored_req();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
